sys_xbar: RTL

Parametrised multi-master, multi-slave system interconnect for the SoC memory bus. It is the generalised successor to the fixed SPI/DMEM/DMA bus. Each of N_MST masters is routed by address decode to one of N_SLV slave ports. Every slave has its own arbiter, so independent master/slave pairs proceed in parallel. The block adds round-robin or fixed-priority arbitration, burst lock, per-master read-valid, and decode-error reporting, and keeps the single-cycle SRAM read-latency model.

---
 rtl/sys_xbar_if.sv | 38 +++
 rtl/sys_xbar.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sys_xbar_if.sv
// Bus bundle for sys_xbar: master-side request/response signals and slave-side access signals.
interface sys_xbar_if #(
   parameter int unsigned N_MST = 4,
   parameter int unsigned N_SLV = 4,
   parameter int unsigned AW    = 32,
   parameter int unsigned DW    = 32
);
   logic [N_MST-1:0]    mst_req_i;
   logic [N_MST-1:0]    mst_lock_i;
   logic [N_MST-1:0]    mst_gnt_o;
   logic [N_MST*AW-1:0] mst_addr_i;
   logic [N_MST-1:0]    mst_write_i;
   logic [N_MST-1:0]    mst_read_i;
   logic [N_MST*4-1:0]  mst_size_i;
   logic [N_MST*DW-1:0] mst_din_i;
   logic [N_MST*DW-1:0] mst_dout_o;
   logic [N_MST-1:0]    mst_rvalid_o;
   logic [N_MST-1:0]    mst_err_o;

   logic [N_SLV*AW-1:0] slv_addr_o;
   logic [N_SLV-1:0]    slv_write_o;
   logic [N_SLV-1:0]    slv_read_o;
   logic [N_SLV*4-1:0]  slv_size_o;
   logic [N_SLV*DW-1:0] slv_din_o;
   logic [N_SLV*DW-1:0] slv_dout_i;

   // Port the bus masters attach to
   modport master (
      input  mst_req_i, mst_lock_i, mst_addr_i, mst_write_i, mst_read_i, mst_size_i, mst_din_i,
      output mst_gnt_o, mst_dout_o, mst_rvalid_o, mst_err_o
   );

   // Port the memory-mapped slaves attach to
   modport slave (
      output slv_addr_o, slv_write_o, slv_read_o, slv_size_o, slv_din_o,
      input  slv_dout_i
   );
endinterface

// File: rtl/sys_xbar.sv
// Multi-master / multi-slave crossbar: address decode, per-slave arbitration with burst lock,
// single-cycle read response routing and decode-error reporting.
module sys_xbar #(
   parameter int unsigned         N_MST    = 4,
   parameter int unsigned         N_SLV    = 4,
   parameter int unsigned         AW       = 32,
   parameter int unsigned         DW       = 32,
   parameter logic [N_SLV*AW-1:0] SLV_BASE = {32'h8000_0000, 32'h4000_0000, 32'h2000_0000, 32'h1000_0000},
   parameter logic [N_SLV*AW-1:0] SLV_MASK = {4{32'hF000_0000}},
   parameter bit                  ARB_RR   = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   sys_xbar_if.master mst,
   sys_xbar_if.slave  slv
);
   localparam int unsigned MW = (N_MST > 1) ? $clog2(N_MST) : 1;
   localparam int unsigned SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} lk_state_e;

   lk_state_e        state_q [N_SLV];
   lk_state_e        state_d [N_SLV];
   logic [MW-1:0]    owner_q [N_SLV];
   logic [MW-1:0]    owner_d [N_SLV];
   logic [MW-1:0]    ptr_q   [N_SLV];
   logic [MW-1:0]    ptr_d   [N_SLV];
   logic [MW-1:0]    rsel_q  [N_SLV];
   logic [MW-1:0]    rsel_d  [N_SLV];
   logic [N_SLV-1:0] rv_q, rv_d;
   logic [N_MST-1:0] err_q, err_d;
   logic [N_MST-1:0] erd_q, erd_d;

   logic [N_MST-1:0] hit;
   logic [SW-1:0]    tgt  [N_MST];
   logic [N_MST-1:0] cand [N_SLV];
   logic [N_SLV-1:0] sgnt;
   logic [MW-1:0]    swin [N_SLV];

   logic [N_MST-1:0]    mgnt;
   logic [N_MST-1:0]    mrv;
   logic [N_MST*DW-1:0] mdout;
   logic [N_SLV*AW-1:0] saddr;
   logic [N_SLV-1:0]    swr, srd;
   logic [N_SLV*4-1:0]  ssize;
   logic [N_SLV*DW-1:0] sdin;

   // Address decode; descending scan so the lowest matching slave wins
   always_comb begin
      hit = '0;
      for (int m = 0; m < N_MST; m++) begin
         tgt[m] = '0;
         for (int s = int'(N_SLV) - 1; s >= 0; s--) begin
            if ((mst.mst_addr_i[m*AW +: AW] & SLV_MASK[s*AW +: AW]) == SLV_BASE[s*AW +: AW]) begin
               hit[m] = 1'b1;
               tgt[m] = SW'(s);
            end
         end
      end
   end

   always_comb begin
      for (int s = 0; s < N_SLV; s++) begin
         cand[s] = '0;
         for (int m = 0; m < N_MST; m++) begin
            cand[s][m] = mst.mst_req_i[m] & hit[m] & (tgt[m] == SW'(s));
         end
      end
   end

   // Per-slave lock FSM and arbiter
   always_comb begin : p_arb
      int unsigned idx;
      idx     = 0;
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      sgnt    = '0;
      for (int s = 0; s < N_SLV; s++) begin
         swin[s] = '0;
         if (state_q[s] == S_LOCKED && cand[s][owner_q[s]] && mst.mst_lock_i[owner_q[s]]) begin
            sgnt[s] = 1'b1;
            swin[s] = owner_q[s];
         end else begin
            state_d[s] = S_IDLE;
            // Descending scan: the last hit is the first requester in priority order
            for (int k = int'(N_MST) - 1; k >= 0; k--) begin
               idx = ARB_RR ? (32'(ptr_q[s]) + 32'(k)) % N_MST : 32'(k);
               if (cand[s][MW'(idx)]) begin
                  sgnt[s] = 1'b1;
                  swin[s] = MW'(idx);
               end
            end
         end
         if (sgnt[s]) begin
            if (mst.mst_lock_i[swin[s]]) begin
               state_d[s] = S_LOCKED;
               owner_d[s] = swin[s];
            end else begin
               ptr_d[s] = (32'(swin[s]) == N_MST - 1) ? '0 : swin[s] + MW'(1);
            end
         end
      end
   end

   always_comb begin
      rv_d = '0;
      for (int s = 0; s < N_SLV; s++) begin
         rsel_d[s] = swin[s];
         rv_d[s]   = sgnt[s] & mst.mst_read_i[swin[s]];
      end
      err_d = mst.mst_req_i & ~hit;
      erd_d = err_d & mst.mst_read_i;
   end

   // Forward the winner's access to each slave; decode errors are granted without a slave
   always_comb begin
      mgnt  = err_d;
      saddr = '0;
      swr   = '0;
      srd   = '0;
      ssize = '0;
      sdin  = '0;
      for (int s = 0; s < N_SLV; s++) begin
         for (int m = 0; m < N_MST; m++) begin
            if (sgnt[s] && swin[s] == MW'(m)) begin
               mgnt[m]           = 1'b1;
               saddr[s*AW +: AW] = mst.mst_addr_i[m*AW +: AW];
               swr[s]            = mst.mst_write_i[m];
               srd[s]            = mst.mst_read_i[m];
               ssize[s*4 +: 4]   = mst.mst_size_i[m*4 +: 4];
               sdin[s*DW +: DW]  = mst.mst_din_i[m*DW +: DW];
            end
         end
      end
   end

   // Route last cycle's read data back to its requester
   always_comb begin
      mrv   = err_q & erd_q;
      mdout = '0;
      for (int m = 0; m < N_MST; m++) begin
         for (int s = 0; s < N_SLV; s++) begin
            if (rv_q[s] && rsel_q[s] == MW'(m)) begin
               mrv[m]            = 1'b1;
               mdout[m*DW +: DW] = slv.slv_dout_i[s*DW +: DW];
            end
         end
      end
   end

   assign mst.mst_gnt_o    = mgnt;
   assign mst.mst_rvalid_o = mrv;
   assign mst.mst_dout_o   = mdout;
   assign mst.mst_err_o    = err_q;
   assign slv.slv_addr_o   = saddr;
   assign slv.slv_write_o  = swr;
   assign slv.slv_read_o   = srd;
   assign slv.slv_size_o   = ssize;
   assign slv.slv_din_o    = sdin;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < N_SLV; s++) begin
            state_q[s] <= S_IDLE;
            owner_q[s] <= '0;
            ptr_q[s]   <= '0;
            rsel_q[s]  <= '0;
         end
         rv_q  <= '0;
         err_q <= '0;
         erd_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         rsel_q  <= rsel_d;
         rv_q    <= rv_d;
         err_q   <= err_d;
         erd_q   <= erd_d;
      end
   end
endmodule
